// File: rtl/puzzle_pkg.sv
// Shared types and helpers for the button-sequence puzzle controller.
package puzzle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON,
        SHOW_GAP,
        INPUT,
        FAIL,
        SOLVED
    } state_t;

    // Fibonacci taps 16,14,13,11 mapped onto a left-shifting register (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] onehot2(input logic [1:0] e);
        logic [3:0] r;
        case (e)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puzzle_seq_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle out of reset.
module lfsr16
    import puzzle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else     q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/puzzle_seq_ctrl.sv
// Alarm-dismiss puzzle: shows a random button sequence on the LEDs, then checks the presses.
module puzzle_seq_ctrl
    import puzzle_pkg::*;
#(
    parameter int          SEQ_LEN     = 4,
    parameter int          SHOW_CYC    = 25000000,
    parameter int          GAP_CYC     = 12500000,
    parameter int          TIMEOUT_CYC = 500000000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn_dn,
    output logic [3:0] led,
    output logic       busy,
    output logic       solved,
    output logic [3:0] fail_cnt,
    output logic [2:0] step
);

    localparam int TW = $clog2(max3(SHOW_CYC, GAP_CYC, TIMEOUT_CYC) + 1);
    localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LAST_IDX = 3'(SEQ_LEN - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [15:0]   seq;
    logic [15:0]   lfsr_q;
    logic [3:0]    last_press;
    logic [3:0]    elem_oh;
    logic          btn_any, btn_single, press_ok, press_bad;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign elem_oh    = onehot2(seq[{idx, 1'b0} +: 2]);
    assign btn_any    = |btn_dn;
    assign btn_single = btn_any && ((btn_dn & (btn_dn - 4'd1)) == 4'd0);
    assign press_ok   = btn_single && (btn_dn == elem_oh);
    assign press_bad  = btn_any && !press_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = SHOW_ON;
            SHOW_ON:  if (timer == SHOW_END) state_next = SHOW_GAP;
            SHOW_GAP: if (timer == GAP_END)
                          state_next = (idx == LAST_IDX) ? INPUT : SHOW_ON;
            INPUT: begin
                if (press_bad)          state_next = FAIL;
                else if (press_ok)      state_next = (idx == LAST_IDX) ? SOLVED : INPUT;
                else if (timer == TO_END) state_next = FAIL;
            end
            FAIL:     if (timer == SHOW_END) state_next = SHOW_ON;
            SOLVED:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        led    = 4'd0;
        busy   = 1'b1;
        solved = 1'b0;
        step   = 3'd0;
        case (state)
            IDLE:    busy = 1'b0;
            SHOW_ON: led = elem_oh;
            INPUT: begin
                led  = last_press;
                step = idx;
            end
            FAIL:    led = 4'hF;
            SOLVED:  solved = 1'b1;
            default: ;
        endcase
    end

    // Datapath: the single timer restarts on any state change and on each accepted press.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            idx        <= 3'd0;
            seq        <= 16'd0;
            last_press <= 4'd0;
            fail_cnt   <= 4'd0;
        end else begin
            if (state == IDLE || state_next != state || (state == INPUT && press_ok))
                timer <= '0;
            else
                timer <= timer + TW'(1);

            if (state == IDLE && start) begin
                seq      <= lfsr_q;
                idx      <= 3'd0;
                fail_cnt <= 4'd0;
            end

            if (state == SHOW_GAP && state_next != SHOW_GAP)
                idx <= (state_next == INPUT) ? 3'd0 : idx + 3'd1;
            else if (state == INPUT && press_ok)
                idx <= (state_next == SOLVED) ? 3'd0 : idx + 3'd1;
            else if (state == FAIL && state_next == SHOW_ON)
                idx <= 3'd0;

            if (state == SHOW_GAP && state_next == INPUT)
                last_press <= 4'd0;
            else if (state == INPUT && press_ok)
                last_press <= btn_dn;

            if (state_next == FAIL && state != FAIL && fail_cnt != 4'hF)
                fail_cnt <= fail_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_puzzle_seq_ctrl.sv
// Directed bench for puzzle_seq_ctrl with short timing parameters and an LFSR reference model.
module tb_puzzle_seq_ctrl;

    localparam int          SEQ_LEN     = 3;
    localparam int          SHOW_CYC    = 4;
    localparam int          GAP_CYC     = 2;
    localparam int          TIMEOUT_CYC = 20;
    localparam logic [15:0] SEED        = 16'hACE1;
    localparam int          SHOW_TOTAL  = SEQ_LEN * (SHOW_CYC + GAP_CYC);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn_dn = 4'd0;
    logic [3:0] led;
    logic       busy;
    logic       solved;
    logic [3:0] fail_cnt;
    logic [2:0] step;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lfsr_m;
    logic [15:0] exp_seq;
    logic [3:0]  exp_q[$];

    puzzle_seq_ctrl #(
        .SEQ_LEN     (SEQ_LEN),
        .SHOW_CYC    (SHOW_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SEED        (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn_dn   (btn_dn),
        .led      (led),
        .busy     (busy),
        .solved   (solved),
        .fail_cnt (fail_cnt),
        .step     (step)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11, shifting left.
    always @(posedge clk) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_elem(input int i);
        logic [1:0] e;
        e = exp_seq[2*i +: 2];
        return 4'b0001 << e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b0;
        btn_dn = 4'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        exp_seq = lfsr_m;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] b);
        btn_dn = b;
        tick(1);
        btn_dn = 4'd0;
    endtask

    // Walks the whole show phase; optional noise on btn_dn/start must not disturb it.
    task automatic check_show(input bit noise);
        logic [3:0] exp_led;
        for (int k = 0; k < SHOW_TOTAL; k++)
            exp_q.push_back(((k % (SHOW_CYC + GAP_CYC)) < SHOW_CYC) ?
                            exp_elem(k / (SHOW_CYC + GAP_CYC)) : 4'd0);
        for (int k = 0; k < SHOW_TOTAL; k++) begin
            exp_led = exp_q.pop_front();
            chk("show_led", {12'd0, led}, {12'd0, exp_led});
            chk("show_busy", {15'd0, busy}, 16'd1);
            btn_dn = 4'd0;
            start  = 1'b0;
            if (noise) begin
                case (k)
                    1:  btn_dn = 4'hF;
                    2:  start = 1'b1;
                    4:  btn_dn = 4'b0011;
                    7:  btn_dn = exp_elem(1);
                    10: btn_dn = 4'b0100;
                    default: ;
                endcase
            end
            tick(1);
        end
        btn_dn = 4'd0;
        start  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] w;

        do_reset();
        chk("rst_led", {12'd0, led}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_solved", {15'd0, solved}, 16'd0);
        chk("rst_fail_cnt", {12'd0, fail_cnt}, 16'd0);
        chk("rst_step", {13'd0, step}, 16'd0);

        // 1. show after start, 2. correct entry
        tick(3);
        do_start();
        chk("t1_busy", {15'd0, busy}, 16'd1);
        check_show(1'b0);
        chk("t1_in_led", {12'd0, led}, 16'd0);
        chk("t1_in_step", {13'd0, step}, 16'd0);
        press(exp_elem(0));
        chk("t2_step1", {13'd0, step}, 16'd1);
        chk("t2_led0", {12'd0, led}, {12'd0, exp_elem(0)});
        tick(4);
        press(exp_elem(1));
        chk("t2_step2", {13'd0, step}, 16'd2);
        chk("t2_led1", {12'd0, led}, {12'd0, exp_elem(1)});
        tick(4);
        press(exp_elem(2));
        chk("t2_solved", {15'd0, solved}, 16'd1);
        chk("t2_solved_busy", {15'd0, busy}, 16'd1);
        chk("t2_solved_led", {12'd0, led}, 16'd0);
        tick(1);
        chk("t2_solved_off", {15'd0, solved}, 16'd0);
        chk("t2_idle_busy", {15'd0, busy}, 16'd0);
        chk("t2_fail_cnt", {12'd0, fail_cnt}, 16'd0);

        // 3. wrong button at step 1, replay, solve
        tick(5);
        do_start();
        check_show(1'b0);
        press(exp_elem(0));
        chk("t3_step1", {13'd0, step}, 16'd1);
        w = exp_seq[3:2] + 2'd1;
        press(4'b0001 << w);
        chk("t3_fail_cnt", {12'd0, fail_cnt}, 16'd1);
        chk("t3_step0", {13'd0, step}, 16'd0);
        for (int i = 0; i < SHOW_CYC; i++) begin
            chk("t3_fail_led", {12'd0, led}, 16'h000F);
            tick(1);
        end
        check_show(1'b0);
        for (int i = 0; i < SEQ_LEN; i++) begin
            chk("t3_step", {13'd0, step}, 16'(i));
            press(exp_elem(i));
        end
        chk("t3_solved", {15'd0, solved}, 16'd1);
        tick(1);
        chk("t3_idle_busy", {15'd0, busy}, 16'd0);
        chk("t3_fail_cnt_kept", {12'd0, fail_cnt}, 16'd1);

        // 4. timeout, multi-bit press, saturation
        tick(2);
        do_start();
        chk("t4_fail_cnt_clr", {12'd0, fail_cnt}, 16'd0);
        check_show(1'b0);
        tick(TIMEOUT_CYC - 1);
        chk("t4_not_yet", {12'd0, led}, 16'd0);
        tick(1);
        chk("t4_timeout_led", {12'd0, led}, 16'h000F);
        chk("t4_timeout_cnt", {12'd0, fail_cnt}, 16'd1);
        tick(SHOW_CYC + SHOW_TOTAL);
        chk("t4_input_led", {12'd0, led}, 16'd0);
        press(4'b0011);
        chk("t4_multi_led", {12'd0, led}, 16'h000F);
        chk("t4_multi_cnt", {12'd0, fail_cnt}, 16'd2);
        for (int i = 0; i < 16; i++) begin
            tick(SHOW_CYC + SHOW_TOTAL);
            press(4'b0011);
            chk("t4_sat_cnt", {12'd0, fail_cnt}, 16'((i + 3 > 15) ? 15 : i + 3));
        end

        // 5. noise while showing, then set up a fail for the reset test
        do_reset();
        do_start();
        check_show(1'b1);
        chk("t5_fail_cnt", {12'd0, fail_cnt}, 16'd0);
        chk("t5_step", {13'd0, step}, 16'd0);
        chk("t5_led", {12'd0, led}, 16'd0);
        press(exp_elem(0));
        press(exp_elem(1));
        chk("t5_step2", {13'd0, step}, 16'd2);
        press(4'b1100);
        chk("t5_fail_cnt1", {12'd0, fail_cnt}, 16'd1);
        tick(SHOW_CYC);
        check_show(1'b0);
        press(exp_elem(0));
        press(exp_elem(1));
        chk("t6_step2", {13'd0, step}, 16'd2);

        // 6. reset mid-puzzle together with the final correct press
        rst    = 1'b1;
        btn_dn = exp_elem(2);
        tick(1);
        rst    = 1'b0;
        btn_dn = 4'd0;
        chk("t6_led", {12'd0, led}, 16'd0);
        chk("t6_busy", {15'd0, busy}, 16'd0);
        chk("t6_step", {13'd0, step}, 16'd0);
        chk("t6_fail_cnt", {12'd0, fail_cnt}, 16'd0);
        chk("t6_solved", {15'd0, solved}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t6_solved_after", {15'd0, solved}, 16'd0);
            chk("t6_busy_after", {15'd0, busy}, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
